uncached_dbus_ctrl: RTL and testbench
=====================================

Name: uncached_dbus_ctrl

Overview:
Responder for the execute stage's uncached data memory requests. It takes a word-level request (physical address, byte enables, pre-shifted write data) and performs it on a single-beat AXI-style bus.
- Writes are posted into a small in-order write buffer.
- Reads block until all buffered writes have completed.
- Sits between the memory pipeline stage and the uncached arbiter port.

Parameters:
WBUF_DEPTH, 4, write-buffer entries (power of two, >=2)
ADDR_WIDTH, 32, physical address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_write  in  1  1=store, 0=load
req_paddr  in  ADDR_WIDTH  physical address
req_wrdata  in  32  lane-aligned store data
req_byteenable  in  4  byte lanes
rsp_valid  out  1  one-cycle pulse, load data valid
rsp_rdata  out  32  full bus word for the load
wbuf_empty  out  1  no buffered or in-flight writes (used by SYNC/CACHE)
araddr  out  ADDR_WIDTH  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_WIDTH  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (rst low, asynchronous):
  - All valids, rready, bready, rsp_valid and req_ready are 0.
  - rsp_rdata is 0; wbuf_empty is 1.
  - Buffer pointers and count are 0; both FSMs go to IDLE.
  - Reset mid-transaction abandons the transaction; no bus signal is held.
- Size and address encoding, from byteenable:
  - 1111 -> size 2, addr[1:0]=00.
  - 0011/1100 -> size 1, addr[1:0]=00/10.
  - Single bit -> size 0, addr[1:0]= index of the set bit.
  - Any other pattern (SWL/SWR/LWL/LWR) -> size 2, addr[1:0]=00, wstrb=byteenable.
  - wstrb always equals req_byteenable.
- req_ready is combinational from registered state only:
  - Write: count < WBUF_DEPTH.
  - Read: count==0, write FSM IDLE, read FSM IDLE.
- Write buffer:
  - FIFO of {addr, size, data, strb}. An accepted store enqueues at the tail and count increments.
  - An entry is freed (count decrements) on the B handshake (bvalid & bready).
  - Enqueue and free in the same cycle leaves count unchanged.
  - Full-state req_ready uses the pre-free count, so a store is not accepted in the cycle the full buffer frees an entry.
  - Pointers wrap modulo WBUF_DEPTH.
- Write FSM:
  - W_IDLE -> W_SEND when count>0. awvalid and wvalid rise the cycle after entering W_SEND, driven from the head entry.
  - AW and W handshakes are tracked independently: each valid drops after its own handshake; either order or simultaneous is allowed.
  - W_SEND -> W_RESP once both handshakes are done. bready=1 only in W_RESP.
  - W_RESP -> W_IDLE on bvalid; head pointer advances.
  - Back-to-back entries re-enter W_SEND the next cycle.
- Read FSM:
  - R_IDLE -> R_ADDR on accepted load; araddr and arsize are registered from the request.
  - In R_ADDR, arvalid=1; on arready -> R_DATA.
  - In R_DATA, rready=1; on rvalid, capture rdata -> R_IDLE.
  - rsp_valid pulses exactly one cycle after the R handshake, with rsp_rdata = captured word.
  - rsp_rdata holds its value until the next load completes.
  - Zero-wait bus latency: accept at cycle 0, arvalid at 1, R handshake at 2 (if rvalid), rsp_valid at 3.
- Ordering:
  - A load is never accepted while any write is buffered or in flight (strict program order).
  - Stores may be accepted while a read is outstanding only if req_ready permits; since reads block further requests at the pipeline, this never occurs in practice, but the buffer still accepts.
- wbuf_empty = (count==0) & write FSM IDLE, registered-state based.
- Bus responses (rresp/bresp) are not checked; errors are ignored.

Test Plan:
- Reset: hold rst low 3 cycles with random bus inputs -> all valids 0, req_ready 0, wbuf_empty 1. Release -> req_ready 1 for a load.
- Zero-wait load: addr 0x1FC00004, be 1111, arready=rvalid=1, rdata 0xDEADBEEF -> araddr 0x1FC00004, arsize 2, rsp_valid pulse at cycle 3, rsp_rdata 0xDEADBEEF.
- Byte/half encoding: store be 0100 addr 0xA0000001 -> awaddr 0xA0000002, awsize 0, wstrb 0100. Load be 1100 -> araddr[1:0]=10, arsize 1.
- Buffer full: awready=0, issue 5 consecutive stores -> first 4 accepted, req_ready 0 on the 5th. Release awready/wready/bvalid -> writes drain in issue order, 5th accepted after the first B handshake.
- Read-after-write ordering: one store then a load with bvalid delayed 10 cycles -> load not accepted (no arvalid) until cycle after the B handshake and wbuf_empty=1.
- Split handshakes and reset mid-operation:
  - wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held, single B accepted.
  - Assert rst while in R_DATA -> arvalid/rready/rsp_valid 0 immediately, no rsp_valid after release.

Source files
------------

// File: rtl/uncached_dbus_ctrl.sv
// Uncached data-bus responder: posts stores into an in-order write buffer and
// issues loads on a single-beat AXI-style bus once all buffered stores have drained.
module uncached_dbus_ctrl #(
    parameter int WBUF_DEPTH = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_paddr,
    input  logic [31:0]           req_wrdata,
    input  logic [3:0]            req_byteenable,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  wbuf_empty,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_WIDTH + 3 + 32 + 4;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WBUF_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t                r_wstate, w_wstate_next;
    rstate_t                r_rstate, w_rstate_next;
    logic [PTR_W-1:0]       r_head, r_tail;
    logic [CNT_W-1:0]       r_count;
    logic                   r_aw_done, w_aw_done_next;
    logic                   r_w_done, w_w_done_next;
    logic [ENT_W-1:0]       r_wbuf [WBUF_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_awaddr, r_araddr;
    logic [2:0]             r_awsize, r_arsize;
    logic [31:0]            r_wdata, r_rsp_rdata;
    logic [3:0]             r_wstrb;
    logic                   r_rsp_valid;

    logic [1:0]             w_lo;
    logic [2:0]             w_size;
    logic [ADDR_WIDTH-1:0]  w_enc_addr;
    logic                   w_ready_wr, w_ready_rd;
    logic                   w_enq, w_ld, w_load_head, w_free, w_capture;
    logic                   w_unused_lo;

    // Low address bits are rebuilt from the byte lanes, so the incoming ones are ignored.
    assign w_unused_lo = &{1'b0, req_paddr[1:0]};

    always_comb begin
        w_lo   = 2'b00;
        w_size = 3'd2;
        case (req_byteenable)
            4'b0011: begin w_size = 3'd1; w_lo = 2'b00; end
            4'b1100: begin w_size = 3'd1; w_lo = 2'b10; end
            4'b0001: begin w_size = 3'd0; w_lo = 2'b00; end
            4'b0010: begin w_size = 3'd0; w_lo = 2'b01; end
            4'b0100: begin w_size = 3'd0; w_lo = 2'b10; end
            4'b1000: begin w_size = 3'd0; w_lo = 2'b11; end
            default: begin w_size = 3'd2; w_lo = 2'b00; end
        endcase
    end

    assign w_enc_addr = {req_paddr[ADDR_WIDTH-1:2], w_lo};

    // Loads wait for a fully drained write path so program order is preserved.
    assign w_ready_wr = (r_count < DEPTH_C);
    assign w_ready_rd = (r_count == '0) && (r_wstate == W_IDLE) && (r_rstate == R_IDLE);
    assign req_ready  = rst & (req_write ? w_ready_wr : w_ready_rd);
    assign w_enq      = req_valid & req_ready & req_write;
    assign w_ld       = req_valid & req_ready & ~req_write;
    assign wbuf_empty = (r_count == '0) && (r_wstate == W_IDLE);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wbuf[r_tail] <= {w_enc_addr, w_size, req_wrdata, req_byteenable};
        end
    end

    always_comb begin
        w_wstate_next  = r_wstate;
        w_aw_done_next = r_aw_done;
        w_w_done_next  = r_w_done;
        w_load_head    = 1'b0;
        w_free         = 1'b0;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        bready         = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (r_count != '0) begin
                    w_wstate_next  = W_SEND;
                    w_load_head    = 1'b1;
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                end
            end
            W_SEND: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if (awvalid && awready) w_aw_done_next = 1'b1;
                if (wvalid && wready)   w_w_done_next  = 1'b1;
                if (w_aw_done_next && w_w_done_next) w_wstate_next = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_wstate_next = W_IDLE;
                    w_free        = 1'b1;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_awaddr  <= '0;
            r_awsize  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
            if (w_load_head) begin
                {r_awaddr, r_awsize, r_wdata, r_wstrb} <= r_wbuf[r_head];
            end
            if (w_enq)  r_tail <= r_tail + PTR_W'(1);
            if (w_free) r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_free);
        end
    end

    assign awaddr = r_awaddr;
    assign awsize = r_awsize;
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;

    always_comb begin
        w_rstate_next = r_rstate;
        w_capture     = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        case (r_rstate)
            R_IDLE: if (w_ld) w_rstate_next = R_ADDR;
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_rstate_next = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_rstate_next = R_IDLE;
                    w_capture     = 1'b1;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate    <= R_IDLE;
            r_araddr    <= '0;
            r_arsize    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rstate    <= w_rstate_next;
            r_rsp_valid <= w_capture;
            if (w_ld) begin
                r_araddr <= w_enc_addr;
                r_arsize <= w_size;
            end
            if (w_capture) r_rsp_rdata <= rdata;
        end
    end

    assign araddr    = r_araddr;
    assign arsize    = r_arsize;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_uncached_dbus_ctrl.sv
// Bench for uncached_dbus_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the buffer and read path.
module tb_uncached_dbus_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_paddr, req_wrdata;
    logic [3:0]  req_byteenable;
    logic        rsp_valid, wbuf_empty;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    uncached_dbus_ctrl #(.WBUF_DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_paddr(req_paddr), .req_wrdata(req_wrdata), .req_byteenable(req_byteenable),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wbuf_empty(wbuf_empty),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } enc_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
    } went_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // transaction-level model
    went_t       wq[$];
    int          pend_w = 0;
    bit          aw_done = 0, w_done = 0;
    int          rphase = 0;      // 0 none, 1 address pending, 2 data pending
    enc_t        exp_ar;
    bit          rsp_due = 0;
    logic [31:0] exp_rdata = '0;
    bit          exp_ready;
    int          stall_aw = 0;
    int          b_count = 0, rsp_count = 0;
    logic [31:0] aw_log[$];

    int n, first_b, acc, b0, r0;
    bit done;

    function automatic enc_t encode(logic [31:0] a, logic [3:0] be);
        enc_t e;
        int ones;
        int lo;
        ones = $countones(be);
        lo = 0;
        for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
        e.addr = {a[31:2], 2'b00};
        e.size = 3'd2;
        if (ones == 1 || be == 4'b0011 || be == 4'b1100) begin
            e.size = (ones == 1) ? 3'd0 : 3'd1;
            e.addr[1:0] = lo[1:0];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        if (!rst) begin
            chk("rst_arvalid", arvalid, 0);
            chk("rst_rready", rready, 0);
            chk("rst_awvalid", awvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_bready", bready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_wbuf_empty", wbuf_empty, 1);
        end else begin
            exp_ready = req_write ? (pend_w < DEPTH) : (pend_w == 0 && rphase == 0);
            chk("req_ready", req_ready, exp_ready);
            chk("wbuf_empty", wbuf_empty, pend_w == 0);
            chk("arvalid", arvalid, rphase == 1);
            if (rphase == 1) begin
                chk("araddr", araddr, exp_ar.addr);
                chk("arsize", arsize, exp_ar.size);
            end
            chk("rready", rready, rphase == 2);
            chk("rsp_valid", rsp_valid, rsp_due);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("bready", bready, pend_w > 0 && aw_done && w_done);
            if (awvalid) begin
                chk("awvalid_allowed", pend_w > 0 && !aw_done, 1);
                if (wq.size() > 0) begin
                    chk("awaddr", awaddr, wq[0].addr);
                    chk("awsize", awsize, wq[0].size);
                end
            end
            if (wvalid) begin
                chk("wvalid_allowed", pend_w > 0 && !w_done, 1);
                if (wq.size() > 0) begin
                    chk("wdata", wdata, wq[0].data);
                    chk("wstrb", wstrb, wq[0].strb);
                end
            end
            if (pend_w > 0 && !aw_done && !w_done) chk("aw_w_together", awvalid, wvalid);
            if (pend_w > 0 && !aw_done && !awvalid) stall_aw++;
            else stall_aw = 0;
            if (stall_aw > 2) chk("aw_issue_latency", stall_aw, 2);
        end
    endtask

    task automatic model_update();
        bit due_next;
        enc_t e;
        went_t w;
        if (!rst) begin
            wq.delete();
            pend_w = 0; aw_done = 0; w_done = 0;
            rphase = 0; rsp_due = 0; exp_rdata = '0; stall_aw = 0;
            return;
        end
        if (rsp_valid) rsp_count++;
        due_next = 0;
        if (rready && rvalid) begin
            due_next = 1;
            exp_rdata = rdata;
            rphase = 0;
            $display("[%0d] READ  addr=%08h size=%0d data=%08h", cyc, exp_ar.addr, exp_ar.size, rdata);
        end
        if (arvalid && arready) rphase = 2;
        if (awvalid && awready) begin
            aw_done = 1;
            aw_log.push_back(awaddr);
        end
        if (wvalid && wready) w_done = 1;
        if (bready && bvalid) begin
            b_count++;
            if (wq.size() > 0) begin
                $display("[%0d] WRITE addr=%08h size=%0d data=%08h strb=%04b",
                         cyc, wq[0].addr, wq[0].size, wq[0].data, wq[0].strb);
                void'(wq.pop_front());
            end
            if (pend_w > 0) pend_w--;
            aw_done = 0;
            w_done = 0;
        end
        if (req_valid && exp_ready) begin
            e = encode(req_paddr, req_byteenable);
            if (req_write) begin
                w.addr = e.addr; w.size = e.size; w.data = req_wrdata; w.strb = req_byteenable;
                wq.push_back(w);
                pend_w++;
            end else begin
                exp_ar = e;
                rphase = 1;
            end
        end
        rsp_due = due_next;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_bus();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rdata = '0;
    endtask

    task automatic rand_bus();
        arready = ($urandom_range(0, 3) != 0);
        rvalid  = ($urandom_range(0, 2) != 0);
        awready = ($urandom_range(0, 2) != 0);
        wready  = ($urandom_range(0, 2) != 0);
        bvalid  = ($urandom_range(0, 2) != 0);
        rdata   = $urandom;
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        req_valid = v; req_write = wr; req_paddr = a; req_byteenable = be; req_wrdata = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_bus();
        set_req(0, 0, '0, 4'hF, '0);

        // reset with random bus activity
        for (int i = 0; i < 3; i++) begin
            rand_bus();
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 4'hF, $urandom);
            sample();
            chk("reset_req_ready", req_ready, 0);
            chk("reset_wbuf_empty", wbuf_empty, 1);
            advance();
        end
        rst = 1;
        idle_bus();
        set_req(0, 0, 32'h0, 4'hF, '0);
        sample();
        chk("release_load_ready", req_ready, 1);
        advance();

        // zero-wait load
        set_req(1, 0, 32'h1FC00004, 4'hF, '0);
        arready = 1; rvalid = 1; rdata = 32'hDEADBEEF;
        sample(); chk("zw_accept", req_ready, 1); advance();
        req_valid = 0;
        sample();
        chk("zw_arvalid_c1", arvalid, 1);
        chk("zw_araddr", araddr, 32'h1FC00004);
        chk("zw_arsize", arsize, 2);
        advance();
        sample(); chk("zw_rready_c2", rready, 1); chk("zw_no_rsp_c2", rsp_valid, 0); advance();
        sample(); chk("zw_rsp_c3", rsp_valid, 1); chk("zw_rdata", rsp_rdata, 32'hDEADBEEF); advance();
        rdata = 32'h0BADF00D;
        sample(); chk("zw_rsp_pulse_end", rsp_valid, 0); chk("zw_rdata_hold", rsp_rdata, 32'hDEADBEEF); advance();
        idle_bus();

        // byte store, then half-word load
        awready = 1; wready = 1; bvalid = 1;
        set_req(1, 1, 32'hA0000001, 4'b0100, 32'h00AB0000);
        sample(); advance();
        req_valid = 0;
        n = 0; sample();
        while (!awvalid && n < 8) begin advance(); sample(); n++; end
        chk("byte_aw_seen", awvalid, 1);
        chk("byte_awaddr", awaddr, 32'hA0000002);
        chk("byte_awsize", awsize, 0);
        chk("byte_wstrb", wstrb, 4'b0100);
        chk("byte_wdata", wdata, 32'h00AB0000);
        advance();
        n = 0; sample();
        while (!wbuf_empty && n < 10) begin advance(); sample(); n++; end
        chk("byte_drained", wbuf_empty, 1);
        advance();
        idle_bus();
        set_req(1, 0, 32'h12345678, 4'b1100, '0);
        arready = 1; rvalid = 1; rdata = 32'hCAFEF00D;
        sample(); chk("half_accept", req_ready, 1); advance();
        req_valid = 0;
        sample(); chk("half_araddr", araddr, 32'h1234567A); chk("half_arsize", arsize, 1); advance();
        sample(); advance();
        sample(); chk("half_rdata", rsp_rdata, 32'hCAFEF00D); advance();
        idle_bus();

        // fill the buffer while the bus stalls
        aw_log.delete();
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1, 32'h80000000 + 32'(i * 4), 4'hF, 32'h100 + 32'(i));
            sample();
            chk("full_ready", req_ready, (i < 4) ? 1 : 0);
            advance();
        end
        awready = 1; wready = 1; bvalid = 1;
        first_b = -1; acc = -1; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            sample();
            if (first_b < 0 && bready && bvalid) first_b = cyc;
            if (req_ready) begin acc = cyc; done = 1; end
            advance();
        end
        chk("full_5th_after_first_b", acc, first_b + 1);
        req_valid = 0;
        n = 0; sample();
        while (!wbuf_empty && n < 40) begin advance(); sample(); n++; end
        chk("full_drained", wbuf_empty, 1);
        advance();
        chk("full_aw_count", aw_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < aw_log.size()) chk("full_aw_order", aw_log[i], 32'h80000000 + 32'(i * 4));
        end
        idle_bus();

        // read after write waits for the B handshake
        awready = 1; wready = 1; bvalid = 0;
        set_req(1, 1, 32'h40000010, 4'hF, 32'h11223344);
        sample(); advance();
        set_req(1, 0, 32'h40000010, 4'hF, '0);
        arready = 1; rvalid = 1; rdata = 32'h13572468;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("raw_blocked", req_ready, 0);
            chk("raw_no_arvalid", arvalid, 0);
            advance();
        end
        bvalid = 1;
        sample(); chk("raw_bready", bready, 1); advance();
        bvalid = 0;
        sample(); chk("raw_ready_after_b", req_ready, 1); chk("raw_wbuf_empty", wbuf_empty, 1); advance();
        req_valid = 0;
        sample(); chk("raw_arvalid", arvalid, 1); advance();
        sample(); advance();
        sample(); chk("raw_rsp", rsp_valid, 1); chk("raw_rdata", rsp_rdata, 32'h13572468); advance();
        idle_bus();

        // W handshake three cycles ahead of AW
        awready = 0; wready = 1; bvalid = 1;
        b0 = b_count;
        set_req(1, 1, 32'h50000020, 4'b0011, 32'h0000BEEF);
        sample(); advance();
        req_valid = 0;
        n = 0; sample();
        while (!wvalid && n < 8) begin advance(); sample(); n++; end
        chk("split_wvalid_seen", wvalid, 1);
        advance();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("split_wvalid_dropped", wvalid, 0);
            chk("split_awvalid_held", awvalid, 1);
            advance();
        end
        awready = 1;
        n = 0; sample();
        while (!wbuf_empty && n < 10) begin advance(); sample(); n++; end
        chk("split_drained", wbuf_empty, 1);
        advance();
        chk("split_single_b", b_count - b0, 1);
        idle_bus();

        // reset while waiting for read data
        set_req(1, 0, 32'h60000000, 4'hF, '0);
        arready = 1; rvalid = 0;
        sample(); advance();
        req_valid = 0;
        sample(); advance();
        sample(); chk("rst_mid_rready", rready, 1); advance();
        rst = 0;
        sample(); chk("rst_mid_arvalid", arvalid, 0); chk("rst_mid_rready_low", rready, 0); advance();
        sample(); advance();
        rst = 1; rvalid = 1; rdata = 32'h77777777;
        r0 = rsp_count;
        for (int k = 0; k < 5; k++) begin
            sample();
            if (k == 0) chk("rst_release_rready", rready, 0);
            advance();
        end
        chk("rst_no_late_rsp", rsp_count - r0, 0);
        idle_bus();

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            rand_bus();
            rst = ($urandom_range(0, 499) != 0);
            set_req(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    $urandom, 4'($urandom_range(0, 15)), $urandom);
            sample();
            advance();
        end

        // drain
        rst = 1;
        req_valid = 0;
        arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1;
        for (int k = 0; k < 40; k++) begin sample(); advance(); end
        sample();
        chk("final_wbuf_empty", wbuf_empty, 1);
        chk("final_rready", rready, 0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
